// File: rtl/hex_scan_decoder.sv
// hex_scan_decoder: watches the multiplexed hex display bus, waits for each
// digit slot to settle, decodes active-low segment patterns back to nibbles
// and publishes the four digits together with frame and error status.
module hex_scan_decoder #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  hex_seg,
    input  logic [3:0]  hex_grid,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic [7:0]  frame_count,
    output logic        seg_err,
    output logic        grid_err,
    output logic        stale
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    SETTLE_C  = 8'(SETTLE);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] STALE = 2'd2;

    logic [7:0]    seg_q;
    logic [3:0]    grid_q;
    logic [11:0]   prev_q;
    logic [7:0]    run_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [1:0]    state;
    logic [3:0]    seen;

    logic [7:0]    run_next;
    logic          capture;
    logic [3:0]    nib;
    logic          nib_ok;
    logic [1:0]    slot;
    logic          slot_ok;
    logic          blank;
    logic          valid_cap;
    logic [3:0]    slot_mask;
    logic [3:0]    seen_next;
    logic [TW-1:0] tmo_next;
    logic          timeout_hit;

    // Register the bus once and track how long the registered pattern has held still.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            seg_q   <= 8'h00;
            grid_q  <= 4'h0;
            prev_q  <= 12'h000;
            run_cnt <= 8'd0;
        end else begin
            seg_q   <= hex_seg;
            grid_q  <= hex_grid;
            prev_q  <= {seg_q, grid_q};
            run_cnt <= run_next;
        end
    end

    // Saturating run length; the capture fires only on the cycle the run first reaches SETTLE.
    always_comb begin
        run_next = 8'd1;
        if ({seg_q, grid_q} == prev_q) begin
            run_next = (run_cnt == SETTLE_C) ? run_cnt : run_cnt + 8'd1;
        end
        capture = (run_next == SETTLE_C) && (run_cnt != SETTLE_C);
    end

    // Map an active-low seven-segment pattern (dp excluded) back to its nibble.
    always_comb begin
        nib    = 4'h0;
        nib_ok = 1'b1;
        case (seg_q[6:0])
            7'h40:   nib = 4'h0;
            7'h79:   nib = 4'h1;
            7'h24:   nib = 4'h2;
            7'h30:   nib = 4'h3;
            7'h19:   nib = 4'h4;
            7'h12:   nib = 4'h5;
            7'h02:   nib = 4'h6;
            7'h78:   nib = 4'h7;
            7'h00:   nib = 4'h8;
            7'h10:   nib = 4'h9;
            7'h08:   nib = 4'hA;
            7'h03:   nib = 4'hB;
            7'h46:   nib = 4'hC;
            7'h21:   nib = 4'hD;
            7'h06:   nib = 4'hE;
            7'h0E:   nib = 4'hF;
            default: nib_ok = 1'b0;
        endcase
    end

    // Classify the grid as a single selected slot, blank, or an illegal multi-select.
    always_comb begin
        slot    = 2'd0;
        slot_ok = 1'b1;
        case (grid_q)
            4'hE:    slot = 2'd0;
            4'hD:    slot = 2'd1;
            4'hB:    slot = 2'd2;
            4'h7:    slot = 2'd3;
            default: slot_ok = 1'b0;
        endcase
        blank       = (grid_q == 4'hF);
        valid_cap   = capture && slot_ok && nib_ok;
        slot_mask   = 4'b0001 << slot;
        seen_next   = seen | slot_mask;
        tmo_next    = (tmo_cnt == TIMEOUT_C) ? tmo_cnt : tmo_cnt + TW'(1);
        timeout_hit = !valid_cap && (state != STALE) && (tmo_next == TIMEOUT_C);
    end

    // Apply captures, frame accounting, error pulses and the IDLE/TRACK/STALE tracking.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            digits      <= 16'h0000;
            digit_valid <= 4'h0;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
            seg_err     <= 1'b0;
            grid_err    <= 1'b0;
            stale       <= 1'b0;
            seen        <= 4'h0;
            tmo_cnt     <= '0;
            state       <= IDLE;
        end else begin
            frame_done <= 1'b0;
            seg_err    <= capture && slot_ok && !nib_ok;
            grid_err   <= capture && !blank && !slot_ok;
            if (valid_cap) begin
                digits[{slot, 2'b00} +: 4] <= nib;
                digit_valid <= digit_valid | slot_mask;
                tmo_cnt     <= '0;
                state       <= TRACK;
                stale       <= 1'b0;
                if (seen_next == 4'hF) begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 8'd1;
                    seen        <= 4'h0;
                end else begin
                    seen <= seen_next;
                end
            end else begin
                tmo_cnt <= tmo_next;
                if (timeout_hit) begin
                    state       <= STALE;
                    stale       <= 1'b1;
                    digit_valid <= 4'h0;
                    seen        <= 4'h0;
                end
            end
        end
    end

endmodule
